// File: rtl/reset_run_watchdog.sv
// Reset stretcher and run watchdog for the simulation harness.
// Optional: define WDOG_FINISH_EN to report and $finish one cycle after a terminal state.
module reset_run_watchdog #(
    parameter int unsigned STRETCH    = 4,
    parameter int unsigned WDOG_LIMIT = 1000,
    parameter int unsigned CW         = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          heartbeat,
    input  logic          done_req,
    output logic          rst_out_n,
    output logic          running,
    output logic          done_ack,
    output logic          timeout,
    output logic [1:0]    status,
    output logic [CW-1:0] cycle_count
);

    localparam int unsigned SCW = (STRETCH > 1) ? $clog2(STRETCH) : 1;
    localparam int unsigned IW  = $clog2(WDOG_LIMIT);

    localparam logic [SCW-1:0] S_LAST = SCW'(STRETCH - 1);
    localparam logic [IW-1:0]  I_LAST = IW'(WDOG_LIMIT - 1);

    typedef enum logic [2:0] {
        S_RESET,
        S_STRETCH,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    state_t         state;
    logic [SCW-1:0] stretch_cnt;
    logic [IW-1:0]  idle_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= S_RESET;
            stretch_cnt <= '0;
            idle_cnt    <= '0;
            rst_out_n   <= 1'b0;
            running     <= 1'b0;
            done_ack    <= 1'b0;
            timeout     <= 1'b0;
            status      <= 2'b00;
            cycle_count <= '0;
        end else begin
            case (state)
                S_RESET: begin
                    state       <= S_STRETCH;
                    stretch_cnt <= '0;
                end
                S_STRETCH: begin
                    if (stretch_cnt == S_LAST) begin
                        state     <= S_RUN;
                        rst_out_n <= 1'b1;
                        running   <= 1'b1;
                        status    <= 2'b10;
                    end else begin
                        stretch_cnt <= stretch_cnt + SCW'(1);
                    end
                end
                S_RUN: begin
                    if (cycle_count != '1)
                        cycle_count <= cycle_count + CW'(1);
                    // completion wins over expiry; a heartbeat only rescues from expiry
                    if (done_req) begin
                        state    <= S_DONE;
                        done_ack <= 1'b1;
                        running  <= 1'b0;
                        status   <= 2'b01;
                    end else if (heartbeat) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == I_LAST) begin
                        state   <= S_TIMEOUT;
                        timeout <= 1'b1;
                        running <= 1'b0;
                        status  <= 2'b11;
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end
                S_DONE, S_TIMEOUT: begin
`ifdef WDOG_FINISH_EN
                    $display("reset_run_watchdog: status=%b cycle_count=%0d",
                             status, cycle_count);
                    $finish;
`else
                    state <= state;
`endif
                end
                default: state <= S_RESET;
            endcase
        end
    end

endmodule

// File: tb/tb_reset_run_watchdog.sv
// Directed bench for reset_run_watchdog: stretch timing, watchdog, done, saturation.
module tb_reset_run_watchdog;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    logic hb_a = 1'b0, dr_a = 1'b0;
    logic hb_b = 1'b0, dr_b = 1'b0;
    logic hb_c = 1'b0, dr_c = 1'b0;

    logic        ro_a, run_a, ack_a, to_a;
    logic [1:0]  st_a;
    logic [31:0] cc_a;
    logic        ro_b, run_b, ack_b, to_b;
    logic [1:0]  st_b;
    logic [31:0] cc_b;
    logic        ro_c, run_c, ack_c, to_c;
    logic [1:0]  st_c;
    logic [3:0]  cc_c;

    int errs   = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    reset_run_watchdog u_a (
        .CLK(CLK), .RST(RST), .heartbeat(hb_a), .done_req(dr_a),
        .rst_out_n(ro_a), .running(run_a), .done_ack(ack_a),
        .timeout(to_a), .status(st_a), .cycle_count(cc_a)
    );

    reset_run_watchdog #(.STRETCH(4), .WDOG_LIMIT(16), .CW(32)) u_b (
        .CLK(CLK), .RST(RST), .heartbeat(hb_b), .done_req(dr_b),
        .rst_out_n(ro_b), .running(run_b), .done_ack(ack_b),
        .timeout(to_b), .status(st_b), .cycle_count(cc_b)
    );

    reset_run_watchdog #(.STRETCH(4), .WDOG_LIMIT(1000), .CW(4)) u_c (
        .CLK(CLK), .RST(RST), .heartbeat(hb_c), .done_req(dr_c),
        .rst_out_n(ro_c), .running(run_c), .done_ack(ack_c),
        .timeout(to_c), .status(st_c), .cycle_count(cc_c)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // 3 cycles of reset, then walk the stretch window edge by edge
    task automatic do_reset();
        RST = 1'b1;
        repeat (3) tick();
        check("rst_ro", 32'(ro_a), 0);
        check("rst_status", 32'(st_a), 0);
        RST = 1'b0;
        repeat (4) tick();
        check("stretch_e4_ro", 32'(ro_a), 0);
        check("stretch_e4_status", 32'(st_a), 0);
        check("stretch_e4_run", 32'(run_a), 0);
        check("stretch_e4_cc", cc_a, 0);
        tick();
        check("stretch_e5_ro", 32'(ro_a), 1);
        check("stretch_e5_status", 32'(st_a), 2);
        check("stretch_e5_run", 32'(run_a), 1);
        check("stretch_e5_cc", cc_a, 0);
        check("stretch_e5_ro_b", 32'(ro_b), 1);
    endtask

    initial begin
        // reset state
        tick();
        check("por_ro", 32'(ro_a), 0);
        check("por_run", 32'(run_a), 0);
        check("por_ack", 32'(ack_a), 0);
        check("por_to", 32'(to_a), 0);
        check("por_cc", cc_a, 0);
        do_reset();

        // heartbeat every 10 cycles keeps the default watchdog quiet
        for (int i = 0; i < 5000; i++) begin
            hb_a = (i % 10 == 9);
            tick();
        end
        hb_a = 1'b0;
        check("hb10_to", 32'(to_a), 0);
        check("hb10_run", 32'(run_a), 1);
        check("hb10_cc", cc_a, 5000);
        check("hb10_status", 32'(st_a), 2);

        // no heartbeat: expiry on the 16th idle edge
        do_reset();
        repeat (15) tick();
        check("idle15_to", 32'(to_b), 0);
        check("idle15_status", 32'(st_b), 2);
        check("idle15_cc", cc_b, 15);
        tick();
        check("idle16_to", 32'(to_b), 1);
        check("idle16_status", 32'(st_b), 3);
        check("idle16_run", 32'(run_b), 0);
        check("idle16_ack", 32'(ack_b), 0);
        check("idle16_cc", cc_b, 16);
        check("idle16_ro", 32'(ro_b), 1);
        hb_b = 1'b1;
        dr_b = 1'b1;
        repeat (5) tick();
        hb_b = 1'b0;
        dr_b = 1'b0;
        check("to_sticky_status", 32'(st_b), 3);
        check("to_sticky_ack", 32'(ack_b), 0);
        check("to_sticky_cc", cc_b, 16);

        // done_req in the same cycle as expiry wins
        do_reset();
        repeat (15) tick();
        dr_b = 1'b1;
        tick();
        dr_b = 1'b0;
        check("race_ack", 32'(ack_b), 1);
        check("race_to", 32'(to_b), 0);
        check("race_status", 32'(st_b), 1);
        check("race_cc", cc_b, 16);
        hb_b = 1'b1;
        repeat (3) tick();
        dr_b = 1'b1;
        repeat (3) tick();
        hb_b = 1'b0;
        dr_b = 1'b0;
        check("done_sticky_status", 32'(st_b), 1);
        check("done_sticky_to", 32'(to_b), 0);
        check("done_sticky_run", 32'(run_b), 0);
        check("done_sticky_cc", cc_b, 16);
        check("done_sticky_ro", 32'(ro_b), 1);

        // mid-run asynchronous reset, then a rerun with done_req held in STRETCH
        do_reset();
        hb_a = 1'b1;
        repeat (50) tick();
        hb_a = 1'b0;
        check("mid_cc", cc_a, 50);
        #2;
        RST = 1'b1;
        #1;
        check("async_ro", 32'(ro_a), 0);
        check("async_run", 32'(run_a), 0);
        check("async_status", 32'(st_a), 0);
        check("async_cc", cc_a, 0);
        dr_a = 1'b1;
        hb_a = 1'b1;
        do_reset();
        dr_a = 1'b0;
        hb_a = 1'b0;
        check("rerun_ack", 32'(ack_a), 0);

        // 4-bit counter saturates at 15
        do_reset();
        hb_c = 1'b1;
        repeat (20) tick();
        hb_c = 1'b0;
        check("sat_cc", 32'(cc_c), 15);
        check("sat_to", 32'(to_c), 0);
        check("sat_run", 32'(run_c), 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
